// File: rtl/piso_bit_feeder.sv
// rtl/piso_bit_feeder.sv - MSB-first parallel-in/serial-out feeder for the 10010 detector (option: PISO_PARITY_EN)
module piso_bit_feeder #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             j,
  output logic             j_valid,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  // Holds the bits still to be sent after the one currently on j, left-aligned.
  logic [WIDTH-2:0] sreg, sreg_n;
  logic             j_n, j_valid_n;
  logic             accept;

`ifdef PISO_PARITY_EN
  logic par, par_n;
`endif

  // Final-bit flags are decoded from state so they need no extra registers.
`ifdef PISO_PARITY_EN
  assign done = (state == PARITY);
`else
  assign done = (state == SHIFT) && (cnt == LAST);
`endif

  assign load_ready = (state == IDLE) || done;
  assign accept     = load_valid && load_ready;

  // State register plus registered serial outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      j       <= IDLE_LEVEL;
      j_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sreg    <= sreg_n;
      j       <= j_n;
      j_valid <= j_valid_n;
`ifdef PISO_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Next-state and next-output logic; an accept always restarts a frame with its MSB.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sreg_n    = sreg;
    j_n       = IDLE_LEVEL;
    j_valid_n = 1'b0;
`ifdef PISO_PARITY_EN
    par_n     = par;
`endif

    case (state)
      SHIFT: begin
        if (cnt != LAST) begin
          j_n       = sreg[WIDTH-2];
          j_valid_n = 1'b1;
          sreg_n    = sreg << 1;
          cnt_n     = cnt + CW'(1);
        end else begin
`ifdef PISO_PARITY_EN
          state_n   = PARITY;
          j_n       = par;
          j_valid_n = 1'b1;
`else
          state_n   = IDLE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (accept) begin
      state_n   = SHIFT;
      cnt_n     = '0;
      sreg_n    = load_data[WIDTH-2:0];
      j_n       = load_data[WIDTH-1];
      j_valid_n = 1'b1;
`ifdef PISO_PARITY_EN
      par_n     = ^load_data;
`endif
    end
  end

endmodule
